seq_divider_gen: RTL and testbench

- Parametrised iterative radix-2 restoring divider; the next generation of the team's fast divider.
- Adds configurable WIDTH, run-time signed/unsigned mode, valid/ready handshakes on input and output, remainder output, and divide-by-zero and overflow flags.
- Sits behind a producer issuing dividend/divisor pairs and in front of a consumer that can apply backpressure.
- Throughput: one operation at a time.

---
 rtl/seq_divider_gen.sv | 129 ++++++++++++
 tb/tb_seq_divider_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_gen.sv
// Iterative radix-2 restoring divider with signed/unsigned mode, valid/ready handshakes and error flags.
// Optional macro SEQ_DIVIDER_EARLY_EXIT_EN: retire at accept when |dividend| < |divisor|.
module seq_divider_gen #(
    parameter int  WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_q;
    logic             neg_r;
    logic             ovf_pend;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic             is_ovf;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
    assign dvd_neg    = signed_mode & dividend[WIDTH-1];
    assign dvs_neg    = signed_mode & divisor[WIDTH-1];
    assign dvd_mag_in = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag_in = dvs_neg ? (~divisor + 1'b1) : divisor;
    assign is_ovf     = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

    // One restoring step: the partial remainder stays below the divisor, so WIDTH+1 bits hold the shift.
    assign shifted  = {prem, dq[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_mag};
    assign ge       = ~diff[WIDTH+1];
    assign next_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign next_q   = {dq[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            prem        <= '0;
            dq          <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg_q    <= dvd_neg ^ dvs_neg;
                        neg_r    <= dvd_neg;
                        dq       <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        prem     <= '0;
                        ovf_pend <= is_ovf;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
                        else if (dvd_mag_in < dvs_mag_in) begin
                            quotient  <= '0;
                            remainder <= dividend;
                            state     <= DONE;
                        end
`endif
                        else begin
                            count <= CNT_W'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= next_rem;
                    dq    <= next_q;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        quotient  <= neg_q ? (~next_q + 1'b1) : next_q;
                        remainder <= neg_r ? (~next_rem + 1'b1) : next_rem;
                        overflow  <= ovf_pend;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_gen.sv
// Directed bench for seq_divider_gen (WIDTH=16): hand-computed results, latency, backpressure and reset abort.
module tb_seq_divider_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int   errors = 0;
    int   checks = 0;
    int   latency;
    logic sawReady;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    localparam int SHORT_LAT = 1;
`else
    localparam int SHORT_LAT = 17;
`endif

    seq_divider_gen #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation and count edges (accept edge = 1) until out_valid, bounded at 40.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sm);
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        dividend    = 16'hDEAD;
        divisor     = 16'h0001;
        signed_mode = ~sm;
        latency     = 1;
        sawReady    = 1'b0;
        while (!out_valid && latency < 40) begin
            if (in_ready) sawReady = 1'b1;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] q, input logic [15:0] r,
                               input logic dbz, input logic ovf, input int lat);
        checkValue({tag, ".latency"}, latency, lat);
        checkValue({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        checkValue({tag, ".quotient"}, {16'b0, quotient}, {16'b0, q});
        checkValue({tag, ".remainder"}, {16'b0, remainder}, {16'b0, r});
        checkValue({tag, ".div_by_zero"}, {31'b0, div_by_zero}, {31'b0, dbz});
        checkValue({tag, ".overflow"}, {31'b0, overflow}, {31'b0, ovf});
        checkValue({tag, ".in_ready_busy"}, {31'b0, sawReady | in_ready}, 32'd0);
    endtask

    task automatic retire(input string tag);
        @(posedge clk);
        #1;
        checkValue({tag, ".retire_valid"}, {31'b0, out_valid}, 32'd0);
        checkValue({tag, ".retire_ready"}, {31'b0, in_ready}, 32'd1);
        checkValue({tag, ".retire_flags"}, {30'b0, div_by_zero, overflow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        dividend    = '0;
        divisor     = '0;
        signed_mode = 1'b0;
        #3;
        checkValue("reset.in_ready", {31'b0, in_ready}, 32'd1);
        checkValue("reset.out_valid", {31'b0, out_valid}, 32'd0);
        checkValue("reset.quotient", {16'b0, quotient}, 32'd0);
        checkValue("reset.remainder", {16'b0, remainder}, 32'd0);
        checkValue("reset.flags", {30'b0, div_by_zero, overflow}, 32'd0);
        #19;
        rst_n = 1'b1;

        applyStimulus(16'd100, 16'd7, 1'b0);
        checkOutput("u100div7", 16'd14, 16'd2, 1'b0, 1'b0, 17);
        retire("u100div7");

        applyStimulus(16'hFFF9, 16'd2, 1'b1);
        checkOutput("sneg7div2", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17);
        retire("sneg7div2");

        applyStimulus(16'd7, 16'hFFFE, 1'b1);
        checkOutput("s7divneg2", 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17);
        retire("s7divneg2");

        applyStimulus(16'd1234, 16'd0, 1'b0);
        checkOutput("u1234div0", 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1);
        retire("u1234div0");

        applyStimulus(16'hFFFB, 16'd0, 1'b1);
        checkOutput("sneg5div0", 16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 1);
        retire("sneg5div0");

        applyStimulus(16'h8000, 16'hFFFF, 1'b1);
        checkOutput("sovf", 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
        retire("sovf");

        applyStimulus(16'h8000, 16'hFFFF, 1'b0);
        checkOutput("u8000divffff", 16'h0000, 16'h8000, 1'b0, 1'b0, SHORT_LAT);
        retire("u8000divffff");

        // Backpressure: result must hold while stray in_valid pulses are ignored.
        out_ready = 1'b0;
        applyStimulus(16'd500, 16'd3, 1'b0);
        checkOutput("bp500div3", 16'd166, 16'd2, 1'b0, 1'b0, 17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 16'd9;
            divisor  = 16'd9;
            @(posedge clk);
            #1;
            checkValue("bp.hold_valid", {31'b0, out_valid}, 32'd1);
            checkValue("bp.hold_ready", {31'b0, in_ready}, 32'd0);
            checkValue("bp.hold_quotient", {16'b0, quotient}, 32'd166);
            checkValue("bp.hold_remainder", {16'b0, remainder}, 32'd2);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        retire("bp500div3");

        // Reset in the middle of a calculation aborts it without a result.
        @(negedge clk);
        dividend    = 16'd100;
        divisor     = 16'd7;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkValue("rstmid.busy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkValue("rstmid.out_valid", {31'b0, out_valid}, 32'd0);
        checkValue("rstmid.in_ready", {31'b0, in_ready}, 32'd1);
        checkValue("rstmid.quotient", {16'b0, quotient}, 32'd0);
        checkValue("rstmid.remainder", {16'b0, remainder}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkValue("rstmid.no_result", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'd3, 16'd1000, 1'b0);
        checkOutput("u3div1000", 16'd0, 16'd3, 1'b0, 1'b0, SHORT_LAT);
        retire("u3div1000");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
